prog_loader: RTL

- Upstream stage of the processor: receives a program image as a byte stream, assembles 16-bit words and writes them sequentially into the instruction memory.
- Holds the processor in reset while loading. After the last word is written it releases the processor and drives Run.
- Counts completed instructions from the processor's Done pulse for debug visibility.

---
 rtl/prog_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program loader: turns a big-endian byte stream (16-bit word count, then words)
// into sequential instruction-memory writes, then releases the processor.
module prog_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_wren,
    output logic              proc_resetn,
    output logic              Run,
    input  logic              Done,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  retired
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_RUN,
        S_ERR
    } state_t;

    state_t             state_q;
    logic [15:0]        len_q;
    logic [ADDR_W-1:0]  index_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic               ready_q;
    logic               wren_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [15:0]        data_q;
    logic               proc_resetn_q;
    logic               run_q;
    logic               busy_q;
    logic               err_q;
    logic [CNT_W-1:0]   retired_q;

    logic               accept;
    logic [15:0]        len_d;
    logic               len_bad;
    logic               last_word;
    logic               to_expire;

    assign accept    = byte_valid && ready_q;
    assign len_d     = {len_q[15:8], byte_data};
    assign len_bad   = (len_d == 16'd0) || (32'(len_d) > (32'd1 << ADDR_W));
    assign last_word = (32'(index_q) + 32'd1) == 32'(len_q);
    assign to_expire = (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            index_q       <= '0;
            to_cnt_q      <= '0;
            ready_q       <= 1'b0;
            wren_q        <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            proc_resetn_q <= 1'b0;
            run_q         <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            retired_q     <= '0;
        end else begin
            wren_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q       <= S_LEN_HI;
                        index_q       <= '0;
                        err_q         <= 1'b0;
                        proc_resetn_q <= 1'b0;
                        run_q         <= 1'b0;
                        ready_q       <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= byte_data;
                        state_q     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= byte_data;
                        if (len_bad) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (accept) begin
                        data_q[15:8] <= byte_data;
                        state_q      <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (accept) begin
                        data_q[7:0] <= byte_data;
                        state_q     <= S_WRITE;
                        wren_q      <= 1'b1;
                        addr_q      <= index_q;
                        ready_q     <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (last_word) begin
                        state_q       <= S_RUN;
                        proc_resetn_q <= 1'b1;
                        run_q         <= 1'b1;
                        busy_q        <= 1'b0;
                        retired_q     <= '0;
                    end else begin
                        index_q <= index_q + ADDR_W'(1);
                        state_q <= S_DATA_HI;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (Done && (retired_q != {CNT_W{1'b1}})) begin
                        retired_q <= retired_q + CNT_W'(1);
                    end
                    if (start) begin
                        state_q       <= S_LEN_HI;
                        index_q       <= '0;
                        proc_resetn_q <= 1'b0;
                        run_q         <= 1'b0;
                        ready_q       <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                S_ERR: begin
                    if (start) begin
                        state_q <= S_LEN_HI;
                        index_q <= '0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // ready_q is high exactly in the byte-accepting states, so it gates the stall timer
            if (ready_q) begin
                if (accept) begin
                    to_cnt_q <= '0;
                end else if (to_expire) begin
                    to_cnt_q <= '0;
                    state_q  <= S_ERR;
                    err_q    <= 1'b1;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
            end
        end
    end

    assign byte_ready  = ready_q;
    assign mem_addr    = addr_q;
    assign mem_data    = data_q;
    assign mem_wren    = wren_q;
    assign proc_resetn = proc_resetn_q;
    assign Run         = run_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign retired     = retired_q;

endmodule
